// File: rtl/syscall_unit.sv
// SYSCALL service engine: print_string / print_char to a console sink, sticky exit, error pulse on bad code.
// Latency: print_char stalls 2 cycles; strings take 1+ cycle per fetch and 1 per byte; tx/mem outputs hold until ready.
module syscall_unit #(
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall,
    input  logic [31:0] vreg,
    input  logic [31:0] areg,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted,
    output logic        err
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LEN_LIMIT = CW'(MAX_LEN);

    localparam logic [31:0] SVC_PRINT_STR  = 32'd4;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EMIT,
        CHAR,
        DONE,
        HALT
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   ptr, ptr_nxt;
    logic [31:0]   wordbuf, wordbuf_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    chr, chr_nxt;
    logic          err_nxt;
    logic [7:0]    cur_byte;
    logic          supported;

    // Big-endian lane select: byte address 0 lives in the top byte of the word.
    always_comb begin
        cur_byte = 8'h00;
        case (ptr[1:0])
            2'd0: cur_byte = wordbuf[31:24];
            2'd1: cur_byte = wordbuf[23:16];
            2'd2: cur_byte = wordbuf[15:8];
            2'd3: cur_byte = wordbuf[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    assign supported = (vreg == SVC_PRINT_STR) || (vreg == SVC_EXIT) ||
                       (vreg == SVC_PRINT_CHAR);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        count_nxt   = count;
        wordbuf_nxt = wordbuf;
        chr_nxt     = chr;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (syscall) begin
                    case (vreg)
                        SVC_PRINT_STR: begin
                            ptr_nxt   = areg;
                            count_nxt = '0;
                            state_nxt = FETCH;
                        end
                        SVC_PRINT_CHAR: begin
                            chr_nxt   = areg[7:0];
                            state_nxt = CHAR;
                        end
                        SVC_EXIT: state_nxt = HALT;
                        default: begin
                            err_nxt   = 1'b1;
                            state_nxt = DONE;
                        end
                    endcase
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    wordbuf_nxt = mem_rdata;
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (cur_byte == 8'h00) begin
                    state_nxt = DONE;
                end else if (tx_ready) begin
                    ptr_nxt   = ptr + 32'd1;
                    count_nxt = count + CW'(1);
                    // Length cap wins over a pending word refetch.
                    if (count_nxt == LEN_LIMIT) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else if (ptr_nxt[1:0] == 2'b00) begin
                        state_nxt = FETCH;
                    end
                end
            end
            CHAR: begin
                if (tx_ready) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            count   <= '0;
            wordbuf <= '0;
            chr     <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            count   <= count_nxt;
            wordbuf <= wordbuf_nxt;
            chr     <= chr_nxt;
            err     <= err_nxt;
        end
    end

    // Handshake outputs decode from registered state only, so they hold until accepted.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (state == EMIT) begin
            tx_valid = (cur_byte != 8'h00);
            tx_data  = cur_byte;
        end else if (state == CHAR) begin
            tx_valid = 1'b1;
            tx_data  = chr;
        end
    end

    assign mem_req  = (state == FETCH);
    assign mem_addr = {ptr[31:2], 2'b00};
    assign halted   = (state == HALT);

    // DONE leaves stall low for one cycle so the pipeline steps past the SYSCALL.
    assign stall = (state == FETCH) || (state == EMIT) || (state == CHAR) ||
                   (state == HALT) || ((state == IDLE) && syscall && supported);

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit (MAX_LEN=4) with memory and console models.
module tb_syscall_unit;

    logic        clk;
    logic        rst;
    logic        syscall;
    logic [31:0] vreg;
    logic [31:0] areg;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;
    int mem_delay = 0;
    int tx_delay = 0;
    int err_cnt = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] fetch_q[$];

    syscall_unit #(.MAX_LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .syscall  (syscall),
        .vreg     (vreg),
        .areg     (areg),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .halted   (halted),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h00004869;
            32'h104: return 32'h21000000;
            32'h200: return 32'h41424344;
            32'h204: return 32'h45464748;
            32'h300: return 32'h41414141;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Memory responder: answers after mem_delay wait cycles, checks request hold.
    initial begin : mem_model
        int wcnt;
        logic pend;
        logic [31:0] paddr;
        wcnt = 0;
        pend = 1'b0;
        paddr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                wcnt = 0;
                mem_ready = 1'b0;
            end else begin
                if (pend) begin
                    checks++;
                    if (mem_req !== 1'b1 || mem_addr !== paddr) begin
                        errors++;
                        $display("FAIL mem_hold: req=%b addr=%h, want req=1 addr=%h", mem_req, mem_addr, paddr);
                    end
                end
                if (mem_ready) begin
                    mem_ready = 1'b0;
                end else if (mem_req === 1'b1) begin
                    if (wcnt == mem_delay) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_word(mem_addr);
                        fetch_q.push_back(mem_addr);
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
                pend = (mem_req === 1'b1) && !mem_ready;
                paddr = mem_addr;
            end
        end
    end

    // Console sink: holds ready low tx_delay cycles per byte, records accepted bytes.
    initial begin : tx_model
        int cnt;
        logic pend;
        logic [7:0] pdat;
        cnt = 0;
        pend = 1'b0;
        pdat = '0;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                cnt = 0;
                tx_ready = (tx_delay == 0);
            end else begin
                if (pend) begin
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== pdat) begin
                        errors++;
                        $display("FAIL tx_hold: valid=%b data=%h, want valid=1 data=%h", tx_valid, tx_data, pdat);
                    end
                end
                if (tx_delay == 0) begin
                    tx_ready = 1'b1;
                end else begin
                    if (tx_ready) begin
                        tx_ready = 1'b0;
                        cnt = 0;
                    end
                    if (tx_valid === 1'b1) begin
                        if (cnt == tx_delay) tx_ready = 1'b1;
                        else cnt++;
                    end
                end
                if (tx_valid === 1'b1 && tx_ready) tx_q.push_back(tx_data);
                pend = (tx_valid === 1'b1) && !tx_ready;
                pdat = tx_data;
            end
        end
    end

    initial begin : err_model
        forever begin
            @(negedge clk);
            if (err === 1'b1) err_cnt++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_call(input logic [31:0] code, input logic [31:0] arg);
        @(negedge clk);
        vreg = code;
        areg = arg;
        syscall = 1'b1;
    endtask

    // Counts stall-high cycles until stall drops (the DONE cycle), then retires the instruction.
    task automatic run_until_done(input int budget, output int sc, output logic done_err,
                                  output logic timed_out);
        int i;
        sc = 0;
        timed_out = 1'b1;
        #1;
        if (stall) sc++;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!stall) begin
                timed_out = 1'b0;
                break;
            end
            sc++;
        end
        done_err = err;
        @(negedge clk);
        syscall = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        syscall = 1'b0;
        vreg = '0;
        areg = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_print_char(input logic [31:0] arg, input logic [7:0] exp_byte);
        int sc, e0;
        logic de, to;
        tx_q.delete();
        e0 = err_cnt;
        start_call(32'd11, arg);
        run_until_done(20, sc, de, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL char_timeout: stall never dropped"); end
        checks++; if (sc != 2) begin errors++; $display("FAIL char_stall_cycles: got %0d want 2", sc); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL char_err: got %b want 0", de); end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== exp_byte) begin
            errors++;
            $display("FAIL char_bytes: got %0d bytes first=%h, want 1 byte %h", tx_q.size(),
                     (tx_q.size() > 0) ? tx_q[0] : 8'hxx, exp_byte);
        end
        @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || tx_valid !== 1'b0 || err_cnt != e0) begin
            errors++;
            $display("FAIL char_idle: stall=%b tx_valid=%b errs=%0d, want 0 0 %0d", stall, tx_valid, err_cnt, e0);
        end
    endtask

    task automatic test_string(input int md, input int td, input int exp_sc);
        int sc, e0;
        logic de, to;
        logic [7:0] exp_tx[3];
        exp_tx[0] = 8'h48; exp_tx[1] = 8'h69; exp_tx[2] = 8'h21;
        tx_q.delete();
        fetch_q.delete();
        mem_delay = md;
        tx_delay = td;
        e0 = err_cnt;
        start_call(32'd4, 32'h102);
        run_until_done(200, sc, de, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL str_timeout: md=%0d td=%0d", md, td); end
        checks++; if (sc != exp_sc) begin errors++; $display("FAIL str_stall_cycles: got %0d want %0d", sc, exp_sc); end
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL str_err: got %b want 0", de); end
        checks++;
        if (tx_q.size() != 3) begin
            errors++;
            $display("FAIL str_count: got %0d bytes want 3", tx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (tx_q[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL str_byte%0d: got %h want %h", i, tx_q[i], exp_tx[i]);
                end
            end
        end
        checks++;
        if (fetch_q.size() != 2 || fetch_q[0] !== 32'h100 || fetch_q[1] !== 32'h104) begin
            errors++;
            $display("FAIL str_fetches: got %0d fetches, want 2 at 100,104", fetch_q.size());
        end
        @(posedge clk);
        #1;
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL str_err_pulses: got %0d want %0d", err_cnt, e0); end
        mem_delay = 0;
        tx_delay = 0;
    endtask

    task automatic test_max_len;
        int sc, e0;
        logic de, to;
        tx_q.delete();
        fetch_q.delete();
        e0 = err_cnt;
        start_call(32'd4, 32'h200);
        run_until_done(100, sc, de, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL maxlen_timeout"); end
        checks++; if (sc != 6) begin errors++; $display("FAIL maxlen_stall_cycles: got %0d want 6", sc); end
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL maxlen_err: got %b want 1", de); end
        checks++;
        if (tx_q.size() != 4 || tx_q[0] !== 8'h41 || tx_q[3] !== 8'h44) begin
            errors++;
            $display("FAIL maxlen_bytes: got %0d bytes, want 41..44", tx_q.size());
        end
        checks++;
        if (fetch_q.size() != 1) begin errors++; $display("FAIL maxlen_fetches: got %0d want 1", fetch_q.size()); end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || stall !== 1'b0 || err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL maxlen_idle: err=%b stall=%b pulses=%0d, want 0 0 %0d", err, stall, err_cnt - e0, 1);
        end
    endtask

    task automatic test_unsupported;
        int sc, e0;
        logic de, to;
        tx_q.delete();
        e0 = err_cnt;
        start_call(32'd7, 32'h0);
        run_until_done(10, sc, de, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL unsup_timeout"); end
        checks++; if (sc != 0) begin errors++; $display("FAIL unsup_stall: got %0d cycles want 0", sc); end
        checks++; if (de !== 1'b1) begin errors++; $display("FAIL unsup_err: got %b want 1", de); end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || stall !== 1'b0 || err_cnt != e0 + 1 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL unsup_after: err=%b stall=%b pulses=%0d bytes=%0d, want 0 0 1 0", err, stall,
                     err_cnt - e0, tx_q.size());
        end
    endtask

    task automatic test_exit;
        tx_q.delete();
        start_call(32'd10, 32'h0);
        #1;
        checks++;
        if (stall !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL exit_decode: stall=%b halted=%b, want 1 0", stall, halted);
        end
        @(posedge clk);
        #1;
        checks++;
        if (halted !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL exit_halt: halted=%b stall=%b, want 1 1", halted, stall);
        end
        @(negedge clk);
        vreg = 32'd11;
        areg = 32'h55;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (halted !== 1'b1 || stall !== 1'b1 || tx_valid !== 1'b0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL exit_absorb: halted=%b stall=%b tx_valid=%b bytes=%0d, want 1 1 0 0", halted, stall,
                     tx_valid, tx_q.size());
        end
        @(negedge clk);
        syscall = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL exit_reset: halted=%b stall=%b, want 0 0", halted, stall);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic seen;
        tx_q.delete();
        tx_delay = 50;
        seen = 1'b0;
        start_call(32'd4, 32'h300);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midrst_emit: tx_valid never rose"); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        syscall = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || tx_data !== 8'h00 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midrst_abort: tx_valid=%b mem_req=%b stall=%b tx_data=%h mem_addr=%h, want all 0",
                     tx_valid, mem_req, stall, tx_data, mem_addr);
        end
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL midrst_bytes: got %0d want 0", tx_q.size()); end
        @(negedge clk);
        rst = 1'b0;
        tx_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || tx_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: stall=%b tx_valid=%b halted=%b, want 0 0 0", stall, tx_valid, halted);
        end
    endtask

    initial begin
        test_reset();
        test_print_char(32'h41, 8'h41);
        test_print_char(32'h100, 8'h00);
        test_string(0, 0, 7);
        test_string(2, 3, 20);
        test_max_len();
        test_unsupported();
        test_exit();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Services the `syscall` request raised by the instruction decoder. It sits beside the control path:
- samples `$v0`/`$a0` when `syscall` is high;
- holds the pipeline via `stall` while the service runs;
- fetches string bytes from data memory;
- streams characters to a console sink over a valid/ready handshake;
- latches a sticky halt on exit.

It replaces simulation-only `$display`/`$finish` handling with synthesizable behaviour.

## Interface
- `MAX_LEN`, default 256: maximum characters emitted per print_string before forced termination.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `syscall`  in  1  decoder flag. High while a SYSCALL instruction is current; stays high while stalled.
- `vreg`  in  32  `$v0` value (service code).
- `areg`  in  32  `$a0` value (argument).
- `stall`  out  1  hold PC/fetch while high.
- `mem_req`  out  1  data-memory read request.
- `mem_addr`  out  32  word-aligned read address.
- `mem_ready`  in  1  read data valid this cycle; completes the request.
- `mem_rdata`  in  32  read word, big-endian byte order.
- `tx_valid`  out  1  console byte valid.
- `tx_data`  out  8  console byte.
- `tx_ready`  in  1  console accepts the byte.
- `halted`  out  1  sticky exit flag.
- `err`  out  1  one-cycle pulse: unsupported code, or MAX_LEN overflow.

## Operation
- **Services:**
  - 4 = print_string at address `areg`.
  - 10 = exit.
  - 11 = print_char `areg[7:0]`.
  - Any other code: `err` pulses for 1 cycle, no stall, transition to DONE.
- **States:** IDLE, FETCH, EMIT, CHAR, DONE, HALT.
- **IDLE:**
  - When `syscall` is high, decode `vreg`.
  - Code 4: latch ptr=`areg`, clear count, go to FETCH.
  - Code 11: latch byte=`areg[7:0]`, go to CHAR.
  - Code 10: go to HALT.
  - Other codes: go to DONE with `err`.
- **FETCH:**
  - Drive `mem_req`=1 and `mem_addr`={ptr[31:2],2'b00}, held stable until `mem_ready`.
  - On `mem_ready`: wordbuf←`mem_rdata`, go to EMIT.
- **EMIT:**
  - Current byte = wordbuf lane ptr[1:0]: 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
  - Byte==0: go to DONE, no transmit.
  - Otherwise `tx_valid`=1, `tx_data`=byte.
  - On `tx_ready`: ptr←ptr+1 (wraps at 2^32), count←count+1.
  - After that handshake, in priority order:
    - count+1==MAX_LEN → `err` pulse, DONE;
    - new ptr[1:0]==0 → FETCH;
    - otherwise stay in EMIT.
- **CHAR:** `tx_valid`=1, `tx_data`=latched byte. On `tx_ready` go to DONE. A zero byte is transmitted as-is.
- **DONE:**
  - `stall`=0 for exactly one cycle so the CPU advances past the SYSCALL.
  - `syscall` is ignored in this state, which prevents retrigger by the same instruction.
  - Next state is IDLE.
- **HALT:** absorbing. `halted`=1 and `stall`=1 until `rst`.
- **stall** (combinational):
  - high in FETCH, EMIT, CHAR and HALT;
  - also high in IDLE when `syscall`=1 and `vreg`∈{4,10,11}.
  - Unsupported codes do not stall.

## Timing
- **Reset values:** state=IDLE; `stall`=0 (assuming `syscall`=0); `mem_req`=0; `mem_addr`=0; `tx_valid`=0; `tx_data`=0; `halted`=0; `err`=0; ptr, count and wordbuf =0.
- **Reset mid-operation:** aborts immediately, asynchronously. `tx_valid` and `mem_req` drop without completing their handshake.
- **Handshake outputs:** `mem_*` and `tx_*` are registered/state-decoded. Once `tx_valid` rises, it and `tx_data` stay stable until `tx_ready`; the same holds for `mem_req`/`mem_addr` until `mem_ready`.
- **print_char latency:** `syscall` edge → CHAR (1 cycle) → DONE on the `tx_ready` cycle. With `tx_ready` tied high, `stall` is high for 2 cycles.
- **print_string, per word:** ≥1 FETCH cycle, plus 1 EMIT cycle per accepted byte (with `tx_ready` high).
- **err:** registered pulse, asserted in the cycle the FSM enters DONE.
- **halted:** rises on entry to HALT, one cycle after the `syscall` edge.

## Test plan
- **print_char:** `vreg`=11, `areg`=0x41, `tx_ready`=1 → one byte 0x41 on tx; `stall` high 2 cycles; DONE then IDLE; `err`=0.
- **Unaligned string:** `vreg`=4, `areg`=0x102. Memory 0x100=0x00004869, 0x104=0x21000000 → tx sequence 0x48,0x69,0x21. Two fetches at 0x100 and 0x104. `stall` drops after 0x00 is found in lane 1.
- **tx backpressure:** same string with `tx_ready` low for 3 cycles on each byte, and `mem_ready` delayed 2 cycles → `tx_data`/`mem_addr` stable throughout; output identical.
- **MAX_LEN overflow:** MAX_LEN=4, string with no NUL → exactly 4 bytes sent, `err` pulse, return to IDLE.
- **Exit:** `vreg`=10 → `halted`=1 next cycle, `stall` stuck at 1. Subsequent `syscall` ignored. `rst` clears both.
- **Unsupported code and mid-operation reset:**
  - `vreg`=7 → `err` pulse, `stall` never high.
  - Assert `rst` during EMIT → `tx_valid` drops immediately, state=IDLE.
